// File: rtl/data_mem_arbiter_pkg.sv
// Shared types and constants for the two-port data-memory arbiter.
package mem_pkg;

  typedef enum logic [1:0] {
    WE_NONE = 2'b00,
    WE_WORD = 2'b01,
    WE_HALF = 2'b10,
    WE_BYTE = 2'b11
  } we_t;

  typedef enum logic {
    IDLE,
    ISSUE
  } arb_state_t;

  localparam logic [31:0] MEM_ADDR_LIMIT = 32'h20000;

  // Offset of the last byte touched by an access; reads cover a full word.
  function automatic logic [1:0] last_byte_offset(input we_t we);
    case (we)
      WE_HALF: return 2'd1;
      WE_BYTE: return 2'd0;
      default: return 2'd3;
    endcase
  endfunction

endpackage

// File: rtl/data_mem_arbiter_if.sv
// Requester-side handshake plus memory-side pins of the data-memory arbiter.
interface data_mem_arbiter_if #(
  parameter int DATA_WIDTH = 32
);
  logic [1:0]                 req_valid_i;
  logic [1:0]                 req_ready_o;
  logic [1:0][1:0]            req_we_i;
  logic [1:0][DATA_WIDTH-1:0] req_addr_i;
  logic [1:0][DATA_WIDTH-1:0] req_wdata_i;
  logic [1:0]                 rsp_valid_o;
  logic                       rsp_err_o;
  logic [DATA_WIDTH-1:0]      rsp_rdata_o;
  logic [1:0]                 mem_we_o;
  logic [DATA_WIDTH-1:0]      mem_a_o;
  logic [DATA_WIDTH-1:0]      mem_wd_o;
  logic [DATA_WIDTH-1:0]      mem_rd_i;

  modport slave (
    input  req_valid_i, req_we_i, req_addr_i, req_wdata_i, mem_rd_i,
    output req_ready_o, rsp_valid_o, rsp_err_o, rsp_rdata_o,
           mem_we_o, mem_a_o, mem_wd_o
  );

  modport master (
    output req_valid_i, req_we_i, req_addr_i, req_wdata_i, mem_rd_i,
    input  req_ready_o, rsp_valid_o, rsp_err_o, rsp_rdata_o,
           mem_we_o, mem_a_o, mem_wd_o
  );
endinterface

// File: rtl/data_mem_arbiter_rr_arb2.sv
// Two-way round-robin picker: a lone requester wins, a tie goes to the
// port that was not granted last.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       grant,
  output logic       any
);
  assign any   = |req;
  assign grant = (req == 2'b11) ? ~last_grant : req[1];
endmodule

// File: rtl/data_mem_arbiter.sv
// Round-robin arbiter sharing one single-port data memory between the CPU
// (port 0) and the DMA/loader (port 1); one access per two cycles.
module data_mem_arbiter
  import mem_pkg::*;
#(
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] ADDR_LIMIT = MEM_ADDR_LIMIT
) (
  input logic              clk,
  input logic              rst,
  data_mem_arbiter_if.slave bus
);

  arb_state_t            state, next_state;
  logic                  last_grant, grant, any, take;
  logic [1:0]            ready;
  we_t                   req_we, cap_we, mem_we;
  logic [DATA_WIDTH-1:0] cap_addr, cap_wdata, rsp_rdata;
  logic                  cap_port, cap_err, req_err, rsp_err;
  logic [DATA_WIDTH:0]   req_last, req_ext;
  logic [1:0]            rsp_valid;

  rr_arb2 u_arb (
    .req        (bus.req_valid_i),
    .last_grant (last_grant),
    .grant      (grant),
    .any        (any)
  );

  assign req_we = we_t'(bus.req_we_i[grant]);

  // One bit wider than the address so an access near the top of the
  // address space cannot wrap back into the window.
  always_comb begin
    req_ext       = '0;
    req_ext[1:0]  = last_byte_offset(req_we);
    req_last      = {1'b0, bus.req_addr_i[grant]} + req_ext;
    req_err       = req_last >= {1'b0, ADDR_LIMIT};
  end

  // NOTE: every output of this block gets a default first, so no path
  // leaves a value unassigned and no latch is inferred.
  always_comb begin
    next_state = state;
    ready      = 2'b00;
    take       = 1'b0;
    mem_we     = WE_NONE;
    case (state)
      IDLE: begin
        if (any && !rst) begin
          ready[grant] = 1'b1;
          take         = 1'b1;
          next_state   = ISSUE;
        end
      end
      ISSUE: begin
        if (!cap_err && !rst) mem_we = cap_we;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= 1'b1;
      cap_we     <= WE_NONE;
      cap_addr   <= '0;
      cap_wdata  <= '0;
      cap_port   <= 1'b0;
      cap_err    <= 1'b0;
      rsp_valid  <= 2'b00;
      rsp_err    <= 1'b0;
      rsp_rdata  <= '0;
    end else begin
      rsp_valid <= 2'b00;
      if (take) begin
        cap_we     <= req_we;
        cap_addr   <= bus.req_addr_i[grant];
        cap_wdata  <= bus.req_wdata_i[grant];
        cap_port   <= grant;
        cap_err    <= req_err;
        last_grant <= grant;
      end
      if (state == ISSUE) begin
        rsp_valid[cap_port] <= 1'b1;
        rsp_err             <= cap_err;
        rsp_rdata           <= (cap_we == WE_NONE && !cap_err) ? bus.mem_rd_i : '0;
      end
    end
  end

  // The capture registers only change on a handshake, so the memory
  // address and write data hold their last values outside ISSUE.
  assign bus.req_ready_o = ready;
  assign bus.mem_we_o    = mem_we;
  assign bus.mem_a_o     = cap_addr;
  assign bus.mem_wd_o    = cap_wdata;
  assign bus.rsp_valid_o = rsp_valid;
  assign bus.rsp_err_o   = rsp_err;
  assign bus.rsp_rdata_o = rsp_rdata;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed bench for data_mem_arbiter: latency, round-robin fairness,
// range errors, reset during ISSUE and withdrawn requests.
module tb_data_mem_arbiter;
  import mem_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  data_mem_arbiter_if #(.DATA_WIDTH(32)) bus ();

  data_mem_arbiter #(
    .DATA_WIDTH (32),
    .ADDR_LIMIT (32'h20000)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int p, input logic v, input logic [1:0] we,
                       input logic [31:0] addr, input logic [31:0] wdata);
    bus.req_valid_i[p] = v;
    bus.req_we_i[p]    = we;
    bus.req_addr_i[p]  = addr;
    bus.req_wdata_i[p] = wdata;
  endtask

  initial begin
    rst = 1'b1;
    drive(0, 1'b0, 2'b00, 32'h0, 32'h0);
    drive(1, 1'b0, 2'b00, 32'h0, 32'h0);
    bus.mem_rd_i = 32'h0;
    tick();
    tick();

    // Reset state, with a CPU request pending that must not be accepted.
    drive(0, 1'b1, 2'b00, 32'h10000, 32'h0);
    bus.mem_rd_i = 32'hDEADBEEF;
    #1;
    check("rst_ready", bus.req_ready_o, 32'h0);
    check("rst_rsp_valid", bus.rsp_valid_o, 32'h0);
    check("rst_err", bus.rsp_err_o, 32'h0);
    check("rst_rdata", bus.rsp_rdata_o, 32'h0);
    check("rst_mem_we", bus.mem_we_o, 32'h0);
    check("rst_mem_a", bus.mem_a_o, 32'h0);
    check("rst_mem_wd", bus.mem_wd_o, 32'h0);

    // CPU read: ready at t, access at t+1, response at t+2.
    rst = 1'b0;
    #1;
    check("t1_ready", bus.req_ready_o, 32'h1);
    tick();
    drive(0, 1'b0, 2'b00, 32'h0, 32'h0);
    check("t1_mem_a", bus.mem_a_o, 32'h10000);
    check("t1_mem_we", bus.mem_we_o, 32'h0);
    check("t1_rsp_early", bus.rsp_valid_o, 32'h0);
    tick();
    check("t1_rsp_valid", bus.rsp_valid_o, 32'h1);
    check("t1_rdata", bus.rsp_rdata_o, 32'hDEADBEEF);
    check("t1_err", bus.rsp_err_o, 32'h0);
    tick();
    check("t1_pulse_end", bus.rsp_valid_o, 32'h0);
    check("t1_rdata_hold", bus.rsp_rdata_o, 32'hDEADBEEF);

    // Both ports requesting continuously from reset: CPU, DMA, CPU, DMA.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    drive(0, 1'b1, 2'b00, 32'h100, 32'h0);
    drive(1, 1'b1, 2'b00, 32'h200, 32'h0);
    bus.mem_rd_i = 32'h11112222;
    #1;
    for (int k = 0; k < 4; k++) begin
      check("t2_grant", bus.req_ready_o, (k % 2 == 1) ? 32'h2 : 32'h1);
      if (k > 0) check("t2_rsp", bus.rsp_valid_o, (k % 2 == 1) ? 32'h1 : 32'h2);
      tick();
      check("t2_busy", bus.req_ready_o, 32'h0);
      tick();
    end
    drive(0, 1'b0, 2'b00, 32'h0, 32'h0);
    drive(1, 1'b0, 2'b00, 32'h0, 32'h0);
    check("t2_rsp_last", bus.rsp_valid_o, 32'h2);

    // DMA half write spanning the limit is rejected.
    drive(1, 1'b1, 2'b10, 32'h1FFFF, 32'h0000ABCD);
    #1;
    check("t3_ready", bus.req_ready_o, 32'h2);
    tick();
    drive(1, 1'b0, 2'b00, 32'h0, 32'h0);
    check("t3_mem_we", bus.mem_we_o, 32'h0);
    check("t3_mem_a", bus.mem_a_o, 32'h1FFFF);
    check("t3_mem_wd", bus.mem_wd_o, 32'h0000ABCD);
    tick();
    check("t3_rsp_valid", bus.rsp_valid_o, 32'h2);
    check("t3_err", bus.rsp_err_o, 32'h1);
    check("t3_rdata", bus.rsp_rdata_o, 32'h0);

    // CPU byte write to the last legal byte goes through.
    drive(0, 1'b1, 2'b11, 32'h1FFFF, 32'h000000A5);
    #1;
    check("t3b_ready", bus.req_ready_o, 32'h1);
    tick();
    drive(0, 1'b0, 2'b00, 32'h0, 32'h0);
    check("t3b_mem_we", bus.mem_we_o, 32'h3);
    check("t3b_mem_wd", bus.mem_wd_o, 32'h000000A5);
    tick();
    check("t3b_rsp_valid", bus.rsp_valid_o, 32'h1);
    check("t3b_err", bus.rsp_err_o, 32'h0);
    check("t3b_rdata", bus.rsp_rdata_o, 32'h0);

    // CPU word write near 2^32 must not wrap into the window.
    drive(0, 1'b1, 2'b01, 32'hFFFFFFFE, 32'h00005555);
    #1;
    check("t4_ready", bus.req_ready_o, 32'h1);
    tick();
    drive(0, 1'b0, 2'b00, 32'h0, 32'h0);
    check("t4_mem_we", bus.mem_we_o, 32'h0);
    check("t4_mem_a", bus.mem_a_o, 32'hFFFFFFFE);
    tick();
    check("t4_rsp_valid", bus.rsp_valid_o, 32'h1);
    check("t4_err", bus.rsp_err_o, 32'h1);

    // Word read ending exactly on the last legal byte.
    drive(0, 1'b1, 2'b00, 32'h1FFFC, 32'h0);
    bus.mem_rd_i = 32'hA5A50F0F;
    #1;
    tick();
    drive(0, 1'b0, 2'b00, 32'h0, 32'h0);
    check("t4b_mem_we", bus.mem_we_o, 32'h0);
    check("t4b_mem_a", bus.mem_a_o, 32'h1FFFC);
    tick();
    check("t4b_rsp_valid", bus.rsp_valid_o, 32'h1);
    check("t4b_err", bus.rsp_err_o, 32'h0);
    check("t4b_rdata", bus.rsp_rdata_o, 32'hA5A50F0F);

    // Reset during ISSUE of a CPU word write: no write, no response.
    drive(0, 1'b1, 2'b01, 32'h100, 32'hCAFE0001);
    #1;
    tick();
    drive(0, 1'b0, 2'b00, 32'h0, 32'h0);
    check("t5_we_pre", bus.mem_we_o, 32'h1);
    rst = 1'b1;
    #1;
    check("t5_we_rst", bus.mem_we_o, 32'h0);
    tick();
    rst = 1'b0;
    #1;
    check("t5_no_rsp", bus.rsp_valid_o, 32'h0);
    drive(0, 1'b1, 2'b00, 32'h300, 32'h0);
    drive(1, 1'b1, 2'b00, 32'h400, 32'h0);
    #1;
    check("t5_cpu_tie", bus.req_ready_o, 32'h1);
    tick();
    drive(0, 1'b0, 2'b00, 32'h0, 32'h0);
    drive(1, 1'b0, 2'b00, 32'h0, 32'h0);
    tick();
    check("t5_rsp_valid", bus.rsp_valid_o, 32'h1);

    // CPU pulses valid while DMA wins the tie, then withdraws.
    bus.mem_rd_i = 32'hCAFEF00D;
    drive(0, 1'b1, 2'b00, 32'h300, 32'h0);
    drive(1, 1'b1, 2'b00, 32'h2000, 32'h0);
    #1;
    check("t6_ready", bus.req_ready_o, 32'h2);
    tick();
    drive(0, 1'b0, 2'b00, 32'h0, 32'h0);
    drive(1, 1'b0, 2'b00, 32'h0, 32'h0);
    check("t6_mem_a", bus.mem_a_o, 32'h2000);
    tick();
    check("t6_rsp_valid", bus.rsp_valid_o, 32'h2);
    check("t6_rdata", bus.rsp_rdata_o, 32'hCAFEF00D);
    check("t6_err", bus.rsp_err_o, 32'h0);
    drive(0, 1'b1, 2'b00, 32'h300, 32'h0);
    drive(1, 1'b1, 2'b00, 32'h2000, 32'h0);
    #1;
    check("t6_last_grant", bus.req_ready_o, 32'h1);
    drive(0, 1'b0, 2'b00, 32'h0, 32'h0);
    drive(1, 1'b0, 2'b00, 32'h0, 32'h0);
    #1;
    check("t6_withdrawn", bus.req_ready_o, 32'h0);
    tick();
    tick();
    check("t6_no_rsp", bus.rsp_valid_o, 32'h0);
    check("t6_mem_we_idle", bus.mem_we_o, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/data_mem_arbiter.md
Name: data_mem_arbiter

Overview:
- Shares the single-port byte-addressed data memory between two requesters: port 0 = CPU load/store, port 1 = DMA/loader.
- Round-robin grant with a valid/ready request handshake and a registered, one-cycle response.
- Drives the memory's WE/A/WD inputs and captures its combinational read data.
- Rejects accesses outside the memory window with an error response and no write.

Parameters:
- DATA_WIDTH, 32, data and address width.
- ADDR_LIMIT, 32'h20000, first byte address outside the memory; an access must lie entirely below it.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- req_valid_i  in  2  per-port request valid; [0]=CPU, [1]=DMA
- req_ready_o  out  2  per-port request accepted this cycle
- req_we_i  in  2x2  per-port op: 00 read, 01 word write, 10 half write, 11 byte write
- req_addr_i  in  2x32  per-port byte address
- req_wdata_i  in  2x32  per-port write data, LSB-aligned
- rsp_valid_o  out  2  per-port one-cycle response pulse
- rsp_err_o  out  1  response is an out-of-range error; qualified by rsp_valid_o
- rsp_rdata_o  out  32  little-endian word read at the request address; 0 on error or write
- mem_we_o  out  2  to memory WE, same encoding as req_we_i
- mem_a_o  out  32  to memory address
- mem_wd_o  out  32  to memory write data
- mem_rd_i  in  32  combinational read data from memory

Behaviour:
- Reset values: state=IDLE, last_grant=1 (CPU wins the first tie), req_ready_o=0, rsp_valid_o=0, rsp_err_o=0, rsp_rdata_o=0, mem_we_o=00, mem_a_o=0, mem_wd_o=0.
- FSM has two states: IDLE and ISSUE.
- IDLE:
  - grant = the only valid port; if both are valid, grant = !last_grant.
  - req_ready_o[grant] = 1 combinationally when req_valid_i[grant]=1 and rst=0.
  - On handshake (valid & ready): capture we/addr/wdata/port and the range check; last_grant <= port; go to ISSUE.
  - With no valid requests, stay in IDLE.
- Range check: size = 4/2/1 bytes for word/half/byte; reads use 4. err = (addr + size - 1) >= ADDR_LIMIT, computed 33-bit so addr near 32'hFFFFFFFF does not wrap.
- ISSUE (exactly one cycle):
  - mem_a_o = captured addr; mem_wd_o = captured wdata.
  - mem_we_o = captured we if no error, else 00; mem_we_o is always 00 when rst=1.
  - At the clock edge ending ISSUE: rsp_rdata_o <= (read & !err) ? mem_rd_i : 0; rsp_err_o <= err; rsp_valid_o[port] <= 1; go to IDLE.
- Timing:
  - Latency: handshake at cycle t, memory access at t+1, rsp_valid_o at t+2.
  - A new handshake may occur at t+2, in the same cycle as the response, so sustained throughput is one access per 2 cycles.
- Outside ISSUE, mem_we_o=00 and mem_a_o/mem_wd_o hold their last values.
- rsp_valid_o is a single-cycle pulse, never high on both ports at once. rsp_err_o/rsp_rdata_o hold until the next response.
- Requesters hold valid, we, addr and wdata stable until ready. Deasserting valid before ready withdraws the request; no state change results.
- Reset asserted in ISSUE: no memory write occurs, no response is produced, and the FSM returns to IDLE.
- Reset asserted with a request pending: the request is not accepted.

Decomposition:
- Package mem_pkg:
  - typedef enum logic [1:0] we_t {WE_NONE=2'b00, WE_WORD=2'b01, WE_HALF=2'b10, WE_BYTE=2'b11}
  - typedef enum arb_state_t {IDLE, ISSUE}
  - constant MEM_ADDR_LIMIT = 32'h20000
- Sub-module rr_arb2: combinational 2-way round-robin picker; inputs req[1:0] and last_grant, outputs grant and any.

Test Plan:
- Reset, then CPU reads 32'h10000 with memory returning 32'hDEADBEEF -> ready[0] at t, mem_a_o=32'h10000 and mem_we_o=00 at t+1, rsp_valid_o=2'b01 with rsp_rdata_o=32'hDEADBEEF and rsp_err_o=0 at t+2.
- Both ports request continuously right after reset -> grants alternate CPU, DMA, CPU, DMA every 2 cycles; no port is granted twice in a row.
- DMA half write addr 32'h1FFFF (spans the limit) -> mem_we_o=00 during ISSUE, rsp_valid_o=2'b10, rsp_err_o=1, rsp_rdata_o=0; CPU byte write to 32'h1FFFF -> mem_we_o=11, no error.
- CPU word write addr 32'hFFFFFFFE -> no 32-bit wrap, rsp_err_o=1, no write issued.
- rst asserted during an ISSUE cycle of a word write -> mem_we_o=00 that cycle, no rsp_valid_o pulse, FSM in IDLE afterwards, CPU wins the next tie.
- CPU asserts valid for 1 cycle while DMA holds the grant, then drops it -> no CPU response, DMA response is correct, and last_grant=1 afterwards.
